systolic_mac_array: RTL and testbench

SYSTOLIC_MAC_ARRAY -- requirements
Module: systolic_mac_array

---
 rtl/systolic_mac_array.sv | 192 +++++++++++++++++++
 tb/tb_systolic_mac_array.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_array.sv
// N x N systolic AND-reduce array (OR / XOR / saturating count per cell) with skewed operand entry,
// a fixed 2N-1 cycle drain and a row-major valid/ready readout that clears the array on its last beat.
module systolic_mac_array #(
  parameter int N     = 4,
  parameter int ACC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             start_read,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last
);

  typedef enum logic [1:0] {ACCUM, DRAIN, READ} state_t;

  localparam int CW = $clog2(N * N);
  localparam logic [CW-1:0] DRAIN_END = CW'(2 * N - 2);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N * N - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             w_take;
  logic             w_flush;
  logic             w_hs;
  logic [1:0]       w_mode;
  logic [ACC_W-1:0] w_sel;

  logic             w_top_a  [N];
  logic             w_top_v  [N];
  logic [1:0]       w_top_m  [N];
  logic             w_left_b [N];
  logic             w_a      [N][N];
  logic             w_b      [N][N];
  logic             w_v      [N][N];
  logic [1:0]       w_m      [N][N];
  logic [ACC_W-1:0] w_acc    [N][N];

  assign w_take = in_valid & in_ready;
  assign w_hs   = out_valid & out_ready;
  assign w_mode = (mode == 2'b11) ? 2'b00 : mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ACCUM;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    w_flush   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = ~clear;
        if (clear)           w_flush = 1'b1;
        else if (start_read) w_next  = DRAIN;
      end
      DRAIN: begin
        if (r_cnt == DRAIN_END) w_next = READ;
      end
      READ: begin
        out_valid = 1'b1;
        out_last  = (r_cnt == LAST_IDX);
        if (out_ready && out_last) begin
          w_flush = 1'b1;
          w_next  = ACCUM;
        end
      end
      default: w_next = ACCUM;
    endcase
  end

  // One counter serves as the drain timer and then as the readout index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_cnt <= '0;
    else if (r_state != w_next)           r_cnt <= '0;
    else if ((r_state == DRAIN) || w_hs)  r_cnt <= r_cnt + CW'(1);
  end

  always_comb begin
    w_sel = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (r_cnt == CW'(r * N + c)) w_sel = w_acc[r][c];
    out_data = out_valid ? w_sel : '0;
  end

  assign w_top_a[0]  = in_a[0];
  assign w_top_v[0]  = w_take;
  assign w_top_m[0]  = w_mode;
  assign w_left_b[0] = in_b[0];

  // Column c's a (with valid/mode) and row c's b are delayed by c cycles so a beat meets at cell (r,c) at time r+c.
  for (genvar c = 1; c < N; c++) begin : g_skew
    logic       r_sa [c];
    logic       r_sv [c];
    logic [1:0] r_sm [c];
    logic       r_sb [c];
    always_ff @(posedge clk or posedge reset) begin
      if (reset || w_flush) begin
        for (int k = 0; k < c; k++) begin
          r_sa[k] <= 1'b0;
          r_sv[k] <= 1'b0;
          r_sm[k] <= 2'b00;
          r_sb[k] <= 1'b0;
        end
      end else begin
        r_sa[0] <= in_a[c];
        r_sv[0] <= w_take;
        r_sm[0] <= w_mode;
        r_sb[0] <= in_b[c];
        for (int k = 1; k < c; k++) begin
          r_sa[k] <= r_sa[k-1];
          r_sv[k] <= r_sv[k-1];
          r_sm[k] <= r_sm[k-1];
          r_sb[k] <= r_sb[k-1];
        end
      end
    end
    assign w_top_a[c]  = r_sa[c-1];
    assign w_top_v[c]  = r_sv[c-1];
    assign w_top_m[c]  = r_sm[c-1];
    assign w_left_b[c] = r_sb[c-1];
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic             w_ai, w_bi, w_vi;
      logic [1:0]       w_mi;
      logic             r_a, r_b, r_v;
      logic [1:0]       r_m;
      logic [ACC_W-1:0] r_acc;

      if (r == 0) begin : g_top
        assign w_ai = w_top_a[c];
        assign w_vi = w_top_v[c];
        assign w_mi = w_top_m[c];
      end else begin : g_mid
        assign w_ai = w_a[r-1][c];
        assign w_vi = w_v[r-1][c];
        assign w_mi = w_m[r-1][c];
      end
      if (c == 0) begin : g_lft
        assign w_bi = w_left_b[r];
      end else begin : g_rgt
        assign w_bi = w_b[r][c-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset || w_flush) begin
          r_a   <= 1'b0;
          r_b   <= 1'b0;
          r_v   <= 1'b0;
          r_m   <= 2'b00;
          r_acc <= '0;
        end else begin
          r_a <= w_ai;
          r_b <= w_bi;
          r_v <= w_vi;
          r_m <= w_mi;
          if (r_v && r_a && r_b) begin
            case (r_m)
              2'b01: begin
                r_acc    <= '0;
                r_acc[0] <= ~r_acc[0];
              end
              2'b10: if (r_acc != '1) r_acc <= r_acc + ACC_W'(1);
              default: r_acc <= ACC_W'(1);
            endcase
          end
        end
      end

      assign w_a[r][c]   = r_a;
      assign w_b[r][c]   = r_b;
      assign w_v[r][c]   = r_v;
      assign w_m[r][c]   = r_m;
      assign w_acc[r][c] = r_acc;
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array (N=4, ACC_W=4): reduction model per cell, readout scoreboard.
module tb_systolic_mac_array;
  localparam int N  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_a = '0;
  logic [N-1:0]  in_b = '0;
  logic          start_read = 1'b0;
  logic          clear = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_data;
  logic          out_last;

  systolic_mac_array #(.N(N), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .start_read(start_read), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int model  [16];
  int exp_rd [16];
  int got    [16];
  int got_ref[16];
  int rd_idx = 0;
  int reads_done = 0;
  bit rand_rdy = 1'b0;
  bit hold = 1'b0;
  int hold_d = 0;
  int hold_l = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Spec-level reduction: product of a column bit and a row bit folded into each cell.
  function automatic void model_beat(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int i;
        i = r * N + c;
        if (a[c] && b[r]) begin
          case (m)
            2'b01:   model[i] = model[i] ^ 1;
            2'b10:   if (model[i] < 15) model[i] = model[i] + 1;
            default: model[i] = model[i] | 1;
          endcase
        end
      end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) model[i] = 0;
  endfunction

  function automatic void snap();
    for (int i = 0; i < 16; i++) exp_rd[i] = model[i];
    model_clear();
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      rd_idx = 0;
      hold = 1'b0;
    end else begin
      chk("ready_valid_exclusive", int'(in_ready & out_valid), 0);
      if (hold && out_valid) begin
        chk("hold_data", int'(out_data), hold_d);
        chk("hold_last", int'(out_last), hold_l);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("rd_data[%0d]", rd_idx), int'(out_data), exp_rd[rd_idx]);
        chk($sformatf("rd_last[%0d]", rd_idx), int'(out_last), int'(rd_idx == 15));
        got[rd_idx] = int'(out_data);
        if (rd_idx == 15) begin
          rd_idx = 0;
          reads_done++;
        end else rd_idx++;
      end
      hold   = out_valid && !out_ready;
      hold_d = int'(out_data);
      hold_l = int'(out_last);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b, input bit sr);
    mode = m; in_a = a; in_b = b; in_valid = 1'b1; start_read = sr;
    #1 chk("beat_in_ready", int'(in_ready), 1);
    model_beat(m, a, b);
    if (sr) snap();
    @(posedge clk); #1;
    in_valid = 1'b0; start_read = 1'b0;
  endtask

  task automatic read_check();
    int n;
    int start;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("drain_cycles", n, 7);
    start = reads_done;
    n = 0;
    while (reads_done == start && n < 500) begin @(posedge clk); #1; n++; end
    chk("read_complete", reads_done - start, 1);
    chk("ready_after_read", int'(in_ready), 1);
  endtask

  task automatic do_read();
    start_read = 1'b1;
    snap();
    @(posedge clk); #1;
    start_read = 1'b0;
    read_check();
  endtask

  task automatic sum_check(input string name, input int req);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += got[i];
    chk(name, s, req);
  endtask

  int or_exp[16];
  logic [3:0] va[7];
  logic [3:0] vb[7];

  initial begin
    int n;
    model_clear();
    for (int i = 0; i < 16; i++) exp_rd[i] = 0;
    or_exp = '{1,0,1,0, 1,0,1,0, 0,0,0,0, 0,0,0,0};
    va = '{4'hF, 4'h3, 4'h1, 4'hC, 4'h5, 4'hF, 4'h2};
    vb = '{4'h1, 4'h2, 4'hF, 4'h4, 4'h8, 4'hF, 4'hA};

    #12;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1 chk("post_reset_in_ready", int'(in_ready), 1);

    do_read();
    sum_check("empty_read_sum", 0);

    beat(2'b00, 4'b0101, 4'b0011, 1'b0);
    do_read();
    for (int i = 0; i < 16; i++) chk($sformatf("or_lit[%0d]", i), got[i], or_exp[i]);

    beat(2'b01, 4'b0101, 4'b0011, 1'b0);
    idle(3);
    beat(2'b01, 4'b0101, 4'b0011, 1'b0);
    do_read();
    sum_check("xor_twice_sum", 0);

    beat(2'b01, 4'hF, 4'hF, 1'b1);
    read_check();
    for (int i = 0; i < 16; i++) chk($sformatf("xor_with_start[%0d]", i), got[i], 1);

    beat(2'b11, 4'b1000, 4'b1000, 1'b0);
    do_read();
    chk("mode11_cell15", got[15], 1);
    sum_check("mode11_sum", 1);

    for (int k = 0; k < 20; k++) begin
      idle($urandom_range(0, 3));
      beat(2'b10, 4'hF, 4'hF, 1'b0);
    end
    do_read();
    for (int i = 0; i < 16; i++) chk($sformatf("count20[%0d]", i), got[i], 15);

    for (int k = 0; k < 10; k++) begin
      idle($urandom_range(0, 2));
      beat(2'b10, 4'hF, 4'hF, 1'b0);
    end
    do_read();
    for (int i = 0; i < 16; i++) chk($sformatf("count10[%0d]", i), got[i], 10);

    for (int k = 0; k < 7; k++) beat(2'b10, va[k], vb[k], 1'b0);
    do_read();
    chk("mixed_cell0", got[0], 3);
    chk("mixed_cell15", got[15], 1);
    for (int i = 0; i < 16; i++) got_ref[i] = got[i];
    for (int k = 0; k < 7; k++) begin
      beat(2'b10, va[k], vb[k], 1'b0);
      idle(k % 2);
    end
    rand_rdy = 1'b1;
    do_read();
    rand_rdy = 1'b0;
    for (int i = 0; i < 16; i++) chk($sformatf("stall_same[%0d]", i), got[i], got_ref[i]);
    do_read();
    sum_check("after_stall_read_sum", 0);

    beat(2'b00, 4'hF, 4'hF, 1'b0);
    idle(1);
    clear = 1'b1; in_valid = 1'b1; mode = 2'b00; in_a = 4'hF; in_b = 4'hF;
    #1 chk("clear_blocks_ready", int'(in_ready), 0);
    model_clear();
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    beat(2'b00, 4'b0001, 4'b0001, 1'b0);
    clear = 1'b1; start_read = 1'b1;
    model_clear();
    @(posedge clk); #1;
    clear = 1'b0; start_read = 1'b0;
    idle(9);
    chk("clear_wins_no_read", int'(out_valid), 0);
    beat(2'b00, 4'b0010, 4'b0100, 1'b0);
    do_read();
    chk("after_clear_cell9", got[9], 1);
    sum_check("after_clear_sum", 1);

    for (int k = 0; k < 3; k++) beat(2'b10, 4'hF, 4'hF, 1'b0);
    start_read = 1'b1;
    snap();
    @(posedge clk); #1;
    start_read = 1'b0;
    n = 0;
    while (rd_idx < 4 && n < 60) begin @(posedge clk); #1; n++; end
    chk("reached_beat5", rd_idx, 4);
    reset = 1'b1;
    model_clear();
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_last", int'(out_last), 0);
    chk("abort_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    do_read();
    sum_check("after_abort_sum", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
